branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 51 +++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating direction counters and a hit counter
module branch_target_buffer #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic        predictTaken,
  output logic [31:0] predictTarget,
  input  logic        controlXferE,
  input  logic [31:0] pcE,
  input  logic        pcSelE,
  input  logic        btbUpdateE,
  input  logic [31:0] btbTargetE,
  output logic [15:0] hitCount
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW = 30 - IDX;
  logic [ENTRIES-1:0] valid;
  logic [TW-1:0] tag [ENTRIES];
  logic [29:0] target [ENTRIES];
  logic [1:0] ctr [ENTRIES];
  logic [IDX-1:0] fidx, eidx;
  logic hit_f, hit_e, unused;
  always_comb begin
    fidx = pcF[IDX+1:2];
    eidx = pcE[IDX+1:2];
    hit_f = valid[fidx] && tag[fidx] == pcF[31:IDX+2];
    hit_e = valid[eidx] && tag[eidx] == pcE[31:IDX+2];
    predictTaken = hit_f && ctr[fidx][1];
    predictTarget = predictTaken ? {target[fidx], 2'b00} : pcF + 32'd4;
  end
  assign unused = ^{pcE[1:0], btbTargetE[1:0]};
  // tag/target storage is deliberately left uninitialised; valid gates every use
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
      hitCount <= '0;
    end else if (controlXferE) begin
      hitCount <= hitCount + {15'd0, hit_e};
      if (pcSelE && btbUpdateE) begin
        valid[eidx] <= 1'b1;
        tag[eidx] <= pcE[31:IDX+2];
        target[eidx] <= btbTargetE[31:2];
        ctr[eidx] <= !hit_e ? 2'b10 : ctr[eidx] == 2'b11 ? 2'b11 : ctr[eidx] + 2'd1;
      end else if (hit_e)
        ctr[eidx] <= ctr[eidx] == 2'b00 ? 2'b00 : ctr[eidx] - 2'd1;
    end
  end
endmodule
